register_file: RTL and testbench

Parametrised multi-port register file for the processor datapath. It generalises the single 32-bit write-enabled register to DEPTH entries of WIDTH bits, with one write port and two asynchronous read ports. After reset, a sequencer clears every entry, one per cycle, and reports progress on `busy`. An optional hardwired-zero entry and optional write-to-read bypass are provided. It sits between decode (read addresses) and writeback (write port).

---
 rtl/register_file.sv | 91 +++++++++
 tb/tb_register_file.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Multi-port register file: one write port, two combinational read ports, post-reset clear sequencer.
// Optional write-to-read forwarding is compiled in with `define REGFILE_BYPASS_EN.
module register_file #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             busy
);

  localparam logic [0:0]    CLEAR    = 1'b0;
  localparam logic [0:0]    READY    = 1'b1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam bit            ZERO_EN  = (ZERO_REG != 0);

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    clr_idx_q, clr_idx_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_en;

  // Reset counts as busy so reads are forced to zero before the first reset edge lands.
  assign busy  = reset || (state_q == CLEAR);
  assign wr_en = write && !busy && !(ZERO_EN && (waddr == '0));

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    mem_d     = mem_q;
    if (reset) begin
      state_d   = CLEAR;
      clr_idx_d = '0;
      mem_d[0]  = '0;
    end else if (state_q == CLEAR) begin
      mem_d[clr_idx_q] = '0;
      if (clr_idx_q == LAST_IDX) begin
        state_d = READY;
      end else begin
        clr_idx_d = clr_idx_q + AW'(1);
      end
    end else if (wr_en) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
    mem_q <= mem_d;
  end

  always_comb begin
    rdata_a = '0;
    if (!busy && !(ZERO_EN && (raddr_a == '0))) begin
      rdata_a = mem_q[raddr_a];
`ifdef REGFILE_BYPASS_EN
      if (write && (raddr_a == waddr)) begin
        rdata_a = wdata;
      end
`endif
    end
  end

  always_comb begin
    rdata_b = '0;
    if (!busy && !(ZERO_EN && (raddr_b == '0))) begin
      rdata_b = mem_q[raddr_b];
`ifdef REGFILE_BYPASS_EN
      if (write && (raddr_b == waddr)) begin
        rdata_b = wdata;
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read/busy values, a negedge monitor checks them.
// Runs a ZERO_REG=1 and a ZERO_REG=0 instance side by side on shared inputs.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr_a = '0;
  logic [4:0]  raddr_b = '0;
  logic [31:0] rdata_a, rdata_b, z_rdata_a, z_rdata_b;
  logic        busy, z_busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ez;
    logic        ebusy;
  } exp_t;

  exp_t sb[$];
  bit   done = 1'b0;

  always #5 clk = ~clk;

  register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .write(write), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy)
  );

  register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) dut_nz (
    .clk(clk), .reset(reset), .write(write), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(z_rdata_a), .rdata_b(z_rdata_b), .busy(z_busy)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp({e.name, ".busy"},    {31'd0, busy},   {31'd0, e.ebusy});
      cmp({e.name, ".nz_busy"}, {31'd0, z_busy}, {31'd0, e.ebusy});
      cmp({e.name, ".rdata_a"}, rdata_a,   e.ea);
      cmp({e.name, ".rdata_b"}, rdata_b,   e.eb);
      cmp({e.name, ".nz_rdata_a"}, z_rdata_a, e.ez);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string nm, input logic [31:0] ea, input logic [31:0] eb,
                           input logic [31:0] ez, input logic ebusy);
    exp_t e;
    e.name = nm; e.ea = ea; e.eb = eb; e.ez = ez; e.ebusy = ebusy;
    sb.push_back(e);
  endtask

  // Counts edges after reset release; write is held until edge 31 when stop_write_at=31.
  task automatic clear_wait(input string nm, input int stop_write_at);
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == stop_write_at) write = 1'b0;
      expect_rd(nm, 32'h0, 32'h0, 32'h0, (i < 32));
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic sweep_zero(input string nm);
    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i);
      raddr_b = 5'(31 - i);
      expect_rd(nm, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
    end
  endtask

  task automatic fill_garbage();
    for (int i = 0; i < 32; i++) begin
      write = 1'b1;
      waddr = 5'(i);
      wdata = 32'hA500_0000 | 32'(i);
      tick();
    end
    write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] same_exp;
    tick();
    tick();
    raddr_a = 5'd3;
    raddr_b = 5'd0;
    expect_rd("reset_state", 32'h0, 32'h0, 32'h0, 1'b1);

    write = 1'b1;
    waddr = 5'd5;
    wdata = 32'hDEAD_BEEF;
    release_reset();
    clear_wait("initial_clear", 31);
    raddr_a = 5'd5;
    raddr_b = 5'd5;
    expect_rd("write_while_busy", 32'h0, 32'h0, 32'h0, 1'b0);

    write = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
    tick();
    write = 1'b0;
    raddr_a = 5'd7; raddr_b = 5'd7;
    expect_rd("normal_write", 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 1'b0);

    write = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    tick();
    write = 1'b0;
    raddr_a = 5'd0; raddr_b = 5'd7;
    expect_rd("zero_reg", 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);

    write = 1'b1; waddr = 5'd3; wdata = 32'h1;
    tick();
    write = 1'b1; waddr = 5'd3; wdata = 32'h2;
    raddr_a = 5'd3; raddr_b = 5'd3;
`ifdef REGFILE_BYPASS_EN
    same_exp = 32'h2;
`else
    same_exp = 32'h1;
`endif
    expect_rd("same_cycle_old", same_exp, same_exp, same_exp, 1'b0);
    tick();
    write = 1'b0;
    expect_rd("same_cycle_new", 32'h2, 32'h2, 32'h2, 1'b0);

    fill_garbage();
    raddr_a = 5'd20; raddr_b = 5'd0;
    expect_rd("garbage_readback", 32'hA500_0014, 32'h0, 32'hA500_0014, 1'b0);
    tick();

    reset = 1'b1;
    tick();
    raddr_a = 5'd20; raddr_b = 5'd7;
    expect_rd("reset_pulse", 32'h0, 32'h0, 32'h0, 1'b1);
    release_reset();
    clear_wait("pulse_clear", 0);
    sweep_zero("pulse_sweep");

    fill_garbage();
    reset = 1'b1;
    tick();
    release_reset();
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    expect_rd("mid_clear_reset", 32'h0, 32'h0, 32'h0, 1'b1);
    release_reset();
    clear_wait("mid_clear", 0);
    sweep_zero("mid_clear_sweep");

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
